// File: rtl/fsm_mon_pkg.sv
// Shared encodings for the observed upstream FSM and for the monitor FSM,
// plus the legal-transition table.
package fsm_mon_pkg;

    localparam logic [1:0] ST_S0  = 2'b00;
    localparam logic [1:0] ST_S1  = 2'b01;
    localparam logic [1:0] ST_S2  = 2'b10;
    localparam logic [1:0] ST_ILL = 2'b11;

    localparam logic [1:0] MON_IDLE  = 2'b00;
    localparam logic [1:0] MON_ARM   = 2'b01;
    localparam logic [1:0] MON_RUN   = 2'b10;
    localparam logic [1:0] MON_FAULT = 2'b11;

    localparam int unsigned DWELL_W = 8;

    // Legal moves of the upstream FSM, including the permitted holds.
    function automatic logic is_legal(input logic [1:0] prev, input logic [1:0] cur);
        logic ok;
        ok = 1'b0;
        case ({prev, cur})
            {ST_S0, ST_S0},
            {ST_S0, ST_S1},
            {ST_S1, ST_S0},
            {ST_S1, ST_S1},
            {ST_S2, ST_S0}: ok = 1'b1;
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr together with inc loads 1 so a restart can count
// the current cycle.
module sat_counter #(
    parameter int unsigned W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && (q < MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/fsm_state_monitor.sv
// Watches a 2-bit upstream FSM, flags illegal moves, S2 entries and stuck
// states, and counts legal transitions while armed and running.
module fsm_state_monitor
    import fsm_mon_pkg::*;
#(
    parameter int unsigned STUCK_LIMIT = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       state_in,
    input  logic             mon_en,
    input  logic             clr,
    output logic             illegal_err,
    output logic             s2_hit,
    output logic             stuck_err,
    output logic [CNT_W-1:0] trans_cnt,
    output logic [1:0]       last_state,
    output logic [1:0]       mon_state
);

    logic [1:0]         state_d;
    logic               run_active;
    logic               arm_active;
    logic               changed;
    logic               illegal;
    logic               s2_entry;
    logic               stuck;
    logic               count_trans;
    logic               dwell_clr;
    logic               dwell_inc;
    logic [DWELL_W-1:0] dwell_q;

    // Event decode for the sample currently on state_in.
    always_comb begin
        run_active  = 1'b0;
        arm_active  = 1'b0;
        changed     = 1'b0;
        illegal     = 1'b0;
        s2_entry    = 1'b0;
        stuck       = 1'b0;
        count_trans = 1'b0;
        dwell_clr   = 1'b0;
        dwell_inc   = 1'b0;

        run_active = mon_en && !clr && (mon_state == MON_RUN);
        arm_active = mon_en && !clr && (mon_state == MON_ARM);
        changed    = (state_in != last_state);

        // A code-11 sample is reported once; the move out of it is not judged again.
        illegal  = (state_in == ST_ILL) ||
                   ((last_state != ST_ILL) && !is_legal(last_state, state_in));
        s2_entry = (state_in == ST_S2) && changed;
        stuck    = !changed && (dwell_q >= DWELL_W'(STUCK_LIMIT - 1));

        count_trans = run_active && changed && !illegal;
        dwell_inc   = arm_active || run_active;
        dwell_clr   = !run_active || changed;
    end

    // Monitor FSM next state; clr wins over a same-cycle error.
    always_comb begin
        state_d = mon_state;
        if (!mon_en) begin
            state_d = MON_IDLE;
        end else if (clr) begin
            state_d = MON_ARM;
        end else begin
            case (mon_state)
                MON_IDLE:  state_d = MON_ARM;
                MON_ARM:   state_d = MON_RUN;
                MON_RUN:   if (illegal || stuck) state_d = MON_FAULT;
                MON_FAULT: state_d = MON_FAULT;
                default:   state_d = MON_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mon_state  <= MON_IDLE;
            last_state <= ST_S0;
        end else begin
            mon_state  <= state_d;
            last_state <= state_in;
        end
    end

    // Sticky flags, only ever set while running.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            illegal_err <= 1'b0;
            s2_hit      <= 1'b0;
            stuck_err   <= 1'b0;
        end else if (run_active) begin
            if (illegal)  illegal_err <= 1'b1;
            if (s2_entry) s2_hit      <= 1'b1;
            if (stuck)    stuck_err   <= 1'b1;
        end
    end

    sat_counter #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_trans_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (count_trans),
        .q   (trans_cnt)
    );

    sat_counter #(
        .W   (DWELL_W),
        .MAX (DWELL_W'(STUCK_LIMIT))
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (dwell_clr),
        .inc (dwell_inc),
        .q   (dwell_q)
    );

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Directed bench: default monitor plus a CNT_W=4 copy on the same stimulus.
module tb_fsm_state_monitor;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ARM   = 2'b01;
    localparam logic [1:0] RUN   = 2'b10;
    localparam logic [1:0] FAULT = 2'b11;

    logic       clk;
    logic       rst;
    logic [1:0] state_in;
    logic       mon_en;
    logic       clr;

    logic       ill0, s20, stk0;
    logic [7:0] cnt0;
    logic [1:0] last0, mon0;
    logic       ill1, s21, stk1;
    logic [3:0] cnt1;
    logic [1:0] last1, mon1;

    int total = 0;
    int bad   = 0;

    fsm_state_monitor u0 (
        .clk(clk), .rst(rst), .state_in(state_in), .mon_en(mon_en), .clr(clr),
        .illegal_err(ill0), .s2_hit(s20), .stuck_err(stk0),
        .trans_cnt(cnt0), .last_state(last0), .mon_state(mon0)
    );

    fsm_state_monitor #(.STUCK_LIMIT(8), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .state_in(state_in), .mon_en(mon_en), .clr(clr),
        .illegal_err(ill1), .s2_hit(s21), .stuck_err(stk1),
        .trans_cnt(cnt1), .last_state(last1), .mon_state(mon1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string tag, input logic ill, input logic s2, input logic stk);
        chk({tag, ".ill"},   32'(ill0), 32'(ill));
        chk({tag, ".s2"},    32'(s20),  32'(s2));
        chk({tag, ".stuck"}, 32'(stk0), 32'(stk));
    endtask

    task automatic chk_reset(input string tag);
        chk_flags(tag, 1'b0, 1'b0, 1'b0);
        chk({tag, ".cnt"},  32'(cnt0),  0);
        chk({tag, ".last"}, 32'(last0), 0);
        chk({tag, ".mon"},  32'(mon0),  32'(IDLE));
        chk({tag, ".u1flags"}, 32'({ill1, s21, stk1}), 0);
        chk({tag, ".u1cnt"},   32'(cnt1),  0);
        chk({tag, ".u1last"},  32'(last1), 0);
        chk({tag, ".u1mon"},   32'(mon1),  32'(IDLE));
    endtask

    initial begin
        rst = 1'b1; mon_en = 1'b0; clr = 1'b0; state_in = 2'b00;
        tick(); tick();
        chk_reset("reset");
        rst = 1'b0;

        // Alternate S0/S1 for ten samples: ARM takes the first, RUN counts nine moves.
        mon_en = 1'b1; state_in = 2'b00;
        tick();
        chk("alt.arm", 32'(mon0), 32'(ARM));
        for (int i = 0; i < 10; i++) begin
            state_in = (i % 2 == 0) ? 2'b00 : 2'b01;
            tick();
        end
        chk("alt.mon", 32'(mon0), 32'(RUN));
        chk("alt.cnt", 32'(cnt0), 9);
        chk("alt.cnt4", 32'(cnt1), 9);
        chk("alt.last", 32'(last0), 1);
        chk_flags("alt", 1'b0, 1'b0, 1'b0);

        // S1 -> S2 is illegal and an S2 entry.
        state_in = 2'b10;
        tick();
        chk_flags("s1s2", 1'b1, 1'b1, 1'b0);
        chk("s1s2.mon", 32'(mon0), 32'(FAULT));
        chk("s1s2.cnt", 32'(cnt0), 9);
        state_in = 2'b00;
        tick();
        chk_flags("sticky", 1'b1, 1'b1, 1'b0);
        chk("sticky.mon", 32'(mon0), 32'(FAULT));
        chk("sticky.last", 32'(last0), 0);

        // Clear, then hold S0 for eight RUN samples.
        clr = 1'b1;
        tick();
        chk_flags("clr", 1'b0, 1'b0, 1'b0);
        chk("clr.mon", 32'(mon0), 32'(ARM));
        chk("clr.cnt", 32'(cnt0), 0);
        clr = 1'b0; state_in = 2'b01;
        tick();
        chk("stuck.run", 32'(mon0), 32'(RUN));
        state_in = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) begin
                chk("stuck.7", 32'(stk0), 0);
                chk("stuck.7mon", 32'(mon0), 32'(RUN));
            end
        end
        chk_flags("stuck.8", 1'b0, 1'b0, 1'b1);
        chk("stuck.mon", 32'(mon0), 32'(FAULT));
        chk("stuck.cnt", 32'(cnt0), 1);
        chk("stuck.u1", 32'(stk1), 1);

        // Dropping mon_en keeps the sticky flag; clr in IDLE clears it.
        mon_en = 1'b0;
        tick();
        chk("idle.mon", 32'(mon0), 32'(IDLE));
        chk("idle.stuck", 32'(stk0), 1);
        clr = 1'b1;
        tick();
        chk("idleclr.stuck", 32'(stk0), 0);
        chk("idleclr.mon", 32'(mon0), 32'(IDLE));
        clr = 1'b0;

        // Code 11 ignored in ARM, flagged in RUN.
        mon_en = 1'b1; state_in = 2'b00;
        tick();
        state_in = 2'b11;
        tick();
        chk_flags("ill.arm", 1'b0, 1'b0, 1'b0);
        chk("ill.arm.mon", 32'(mon0), 32'(RUN));
        chk("ill.arm.last", 32'(last0), 3);
        tick();
        chk_flags("ill.run", 1'b1, 1'b0, 1'b0);
        chk("ill.run.mon", 32'(mon0), 32'(FAULT));

        // mon_en falling on the cycle of an S0 -> S2 move records nothing.
        clr = 1'b1; state_in = 2'b00;
        tick();
        clr = 1'b0;
        tick();
        chk("drop.run", 32'(mon0), 32'(RUN));
        mon_en = 1'b0; state_in = 2'b10;
        tick();
        chk_flags("drop", 1'b0, 1'b0, 1'b0);
        chk("drop.mon", 32'(mon0), 32'(IDLE));

        // Twenty legal moves: 8-bit counter reads 20, 4-bit one saturates at 15.
        mon_en = 1'b1; state_in = 2'b00;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            state_in = (i % 2 == 0) ? 2'b01 : 2'b00;
            tick();
        end
        chk("sat.cnt8", 32'(cnt0), 20);
        chk("sat.cnt4", 32'(cnt1), 15);
        chk("sat.mon", 32'(mon1), 32'(RUN));

        // clr beats a concurrent illegal S0 -> S2.
        clr = 1'b1; state_in = 2'b10;
        tick();
        clr = 1'b0;
        chk_flags("clrerr", 1'b0, 1'b0, 1'b0);
        chk("clrerr.u1", 32'({ill1, s21, stk1}), 0);
        chk("clrerr.mon", 32'(mon1), 32'(ARM));
        chk("clrerr.cnt4", 32'(cnt1), 0);

        // Reset from FAULT, with mon_en still high.
        state_in = 2'b00;
        tick();
        state_in = 2'b11;
        tick();
        chk("pre.rst.mon", 32'(mon0), 32'(FAULT));
        rst = 1'b1; state_in = 2'b01;
        tick();
        chk_reset("rst.fault");
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
